// File: rtl/rom_sequencer.sv
// rom_sequencer: steps ROM addresses 0..last at one word per DIV clocks, registers each word with a strobe
// Ports: clk, rstn (sync, active low), start, stop, last[AW] -> addr[AW] to ROM; rom_data[DW] from ROM
//        -> data[DW], strobe, busy, done. Define ROM_SEQUENCER_LOOP_EN to replay the table until stopped.
module rom_sequencer #(
  parameter int          AW  = 5,
  parameter int          DW  = 4,
  parameter int unsigned DIV = 3_000_000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] data,
  output logic          strobe,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;
  // FETCH and LATCH take one cycle each, so HOLD fills the remaining DIV-2 cycles of the step
  localparam logic [31:0] hold_end = 32'(DIV - 3);
  state_t        state;
  logic [31:0]   cnt;
  logic [AW-1:0] last_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      addr   <= '0;
      data   <= '0;
      strobe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      strobe <= 1'b0;
      done   <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
        addr  <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (start && !stop) begin
            last_q <= last;
            addr   <= '0;
            busy   <= 1'b1;
            state  <= FETCH;
          end
          FETCH: state <= LATCH;
          LATCH: begin
            data   <= rom_data;
            strobe <= 1'b1;
            cnt    <= '0;
            state  <= HOLD;
          end
          HOLD: if (cnt != hold_end) cnt <= cnt + 32'd1;
          else if (addr != last_q) begin
            addr  <= addr + AW'(1);
            state <= FETCH;
          end else begin
`ifdef ROM_SEQUENCER_LOOP_EN
            addr  <= '0;
            done  <= 1'b1;
            state <= FETCH;
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: randomized checks of rom_sequencer against a step-schedule model
module tb_rom_sequencer;
  localparam int AW = 3, DW = 4, DIV = 4;
`ifdef ROM_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 0, rstn = 0, start = 0, stop = 0;
  logic [AW-1:0] last = '0, addr;
  logic [DW-1:0] rom_data = '0, data;
  logic strobe, busy, done;
  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] md = '0;
  rom_sequencer #(.AW(AW), .DW(DW), .DIV(DIV)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .last(last), .addr(addr),
    .rom_data(rom_data), .data(data), .strobe(strobe), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= 4'(addr) + 4'd1;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Expected outputs t edges after the start edge: step k strobes at 2+k*DIV with rom[k]=k+1
  function automatic void model(input int t, input int lst, input logic [3:0] d0, output logic s,
                                output logic [3:0] d, output logic dn, output logic b, output logic [2:0] a);
    int n, k;
    n = lst + 1;
    k = t >= 2 ? (t - 2) / DIV : 0;
    if (LOOP) begin
      b  = 1'b1;
      dn = t > 0 && t % (n * DIV) == 0;
      a  = 3'((t / DIV) % n);
      s  = t >= 2 && (t - 2) % DIV == 0;
      d  = t < 2 ? d0 : 4'(k % n + 1);
    end else begin
      b  = t < n * DIV;
      dn = t == n * DIV;
      a  = 3'(t / DIV < lst ? t / DIV : lst);
      s  = t >= 2 && (t - 2) % DIV == 0 && k <= lst;
      d  = t < 2 ? d0 : 4'((k > lst ? lst : k) + 1);
    end
  endfunction
  task automatic test_reset;
    rstn = 0;
    tick();
    tick();
    n_checks++;
    if ({strobe, data, done, busy, addr} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset strobe/data/done/busy/addr got %b/%0d/%b/%b/%0d exp 0/0/0/0/0", strobe, data, done, busy, addr);
    end
    rstn = 1;
    md = '0;
    tick();
  endtask
  task automatic test_play(input int lst);
    logic s, dn, b;
    logic [3:0] d, d0;
    logic [2:0] a;
    int ncyc;
    ncyc = LOOP ? 3 * (lst + 1) * DIV + 5 : (lst + 1) * DIV + 2;
    d0 = md;
    last = 3'(lst);
    start = 1;
    tick();
    start = 0;
    for (int t = 0; t <= ncyc; t++) begin
      model(t, lst, d0, s, d, dn, b, a);
      n_checks++;
      if ({strobe, data, done, busy, addr} !== {s, d, dn, b, a}) begin
        n_fail++;
        $display("FAIL play last=%0d t=%0d strobe/data/done/busy/addr got %b/%0d/%b/%b/%0d exp %b/%0d/%b/%b/%0d",
                 lst, t, strobe, data, done, busy, addr, s, d, dn, b, a);
      end
      md = d;
      last = 3'($urandom);
      start = (LOOP || t + 2 < (lst + 1) * DIV) ? 1'($urandom) : 1'b0;
      stop = LOOP && t == ncyc;
      tick();
    end
    start = 0;
    stop = 0;
    n_checks++;
    if ({strobe, data, done, busy} !== {1'b0, md, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL play_end last=%0d strobe/data/done/busy got %b/%0d/%b/%b exp 0/%0d/0/0", lst, strobe, data, done, busy, md);
    end
    tick();
  endtask
  task automatic test_abort(input int sedge);
    logic s, dn, b;
    logic [3:0] d, d0, dstop;
    logic [2:0] a;
    d0 = md;
    dstop = md;
    last = 3'd7;
    start = 1;
    tick();
    start = 0;
    for (int t = 0; t <= sedge + 4; t++) begin
      model(t, 7, d0, s, d, dn, b, a);
      if (t >= sedge) {s, d, dn, b, a} = {1'b0, dstop, 1'b0, 1'b0, 3'd0};
      n_checks++;
      if ({strobe, data, done, busy, addr} !== {s, d, dn, b, a}) begin
        n_fail++;
        $display("FAIL abort at=%0d t=%0d strobe/data/done/busy/addr got %b/%0d/%b/%b/%0d exp %b/%0d/%b/%b/%0d",
                 sedge, t, strobe, data, done, busy, addr, s, d, dn, b, a);
      end
      if (t == sedge - 1) dstop = d;
      md = d;
      stop = t == sedge - 1;
      tick();
    end
    stop = 0;
  endtask
  task automatic test_priority;
    start = 1;
    stop = 1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if ({busy, strobe, done} !== 3'b0) begin
        n_fail++;
        $display("FAIL priority t=%0d busy/strobe/done got %b/%b/%b exp 0/0/0", t, busy, strobe, done);
      end
    end
    start = 0;
    stop = 0;
    tick();
  endtask
  task automatic test_mid_reset;
    last = 3'd5;
    start = 1;
    tick();
    start = 0;
    repeat (7) tick();
    rstn = 0;
    tick();
    rstn = 1;
    n_checks++;
    if ({strobe, data, done, busy, addr} !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_reset strobe/data/done/busy/addr got %b/%0d/%b/%b/%0d exp 0/0/0/0/0", strobe, data, done, busy, addr);
    end
    md = '0;
    tick();
  endtask
  initial begin
    tick();
    test_reset();
    test_play(2);
    test_play(0);
    test_play(7);
    repeat (3) test_play(int'($urandom_range(0, 7)));
    test_abort(7);
    test_abort(6);
    test_abort(int'($urandom_range(1, 8 * DIV - 1)));
    test_priority();
    test_mid_reset();
    test_play(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
